serial_loader: RTL and testbench

Serial bootstrap loader for the 6502 computer. It receives load packets over an 8N1 serial line and writes the payload into system memory as a bus initiator. While it writes, it holds the CPU off the bus. It answers each packet with a one-byte ACK/NAK on its own transmit line, so a host can push a program image into RAM without a ROM monitor.

---
 rtl/serial_loader.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_serial_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_loader.sv
// serial_loader: serial bootstrap loader for the 6502 computer.
// Receives 8N1 load packets ('L', addr_hi, addr_lo, len, data..., chk), writes the payload to
// memory as a bus initiator while holding the CPU off the bus, and answers ACK (0x06) or
// NAK (0x15) on its own transmit line.
// Ports:
//   clk          system clock, everything on rising edge
//   reset        synchronous, active-high reset
//   rxd_line     serial input (idle high)
//   txd_line     serial reply output (idle high)
//   mem_address  write address, increments the cycle after each strobe
//   mem_data     write data
//   mem_write    one-cycle write strobe
//   cpu_hold     high while a packet (and its reply) is in progress
//   load_done    one-cycle pulse on good checksum
//   load_error   one-cycle pulse on bad checksum, framing error or timeout
module serial_loader #(
  parameter int unsigned CLK_RATE     = 12000000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned CLK_DIVISOR  = CLK_RATE / BAUD_RATE,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd_line,
  output logic        txd_line,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLK_DIVISOR;
  localparam int unsigned ToW           = $clog2(TimeoutCycles + 1);
  localparam logic [11:0] HalfBit       = 12'(CLK_DIVISOR / 2 - 1);
  localparam logic [11:0] FullBit       = 12'(CLK_DIVISOR - 1);
  localparam logic [7:0]  ByteLoad      = 8'h4C;
  localparam logic [7:0]  ByteAck       = 8'h06;
  localparam logic [7:0]  ByteNak       = 8'h15;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {PIdle, PAddrHi, PAddrLo, PLen, PData, PChk, PReply} p_state_e;

  // Receiver
  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [11:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        byte_valid, frame_err;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (!rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = HalfBit;
        end
      end
      RxStart: begin
        if (rx_cnt_q != 12'd0) begin
          rx_cnt_d = rx_cnt_q - 12'd1;
        end else if (rx_sync_q) begin
          rx_state_d = RxIdle;  // false start
        end else begin
          rx_state_d = RxData;
          rx_cnt_d   = FullBit;
          rx_bit_d   = 3'd0;
        end
      end
      RxData: begin
        if (rx_cnt_q != 12'd0) begin
          rx_cnt_d = rx_cnt_q - 12'd1;
        end else begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = FullBit;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q != 12'd0) begin
          rx_cnt_d = rx_cnt_q - 12'd1;
        end else begin
          rx_state_d = RxIdle;
          if (rx_sync_q) byte_valid = 1'b1;
          else frame_err = 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Transmitter: start bit driven on load, then 8 data bits and 2 stop bits from the shifter
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy_q, tx_busy_d;
  logic        txd_q, txd_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_left_q, tx_left_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;

  always_comb begin
    tx_busy_d  = tx_busy_q;
    txd_d      = txd_q;
    tx_shift_d = tx_shift_q;
    tx_left_d  = tx_left_q;
    tx_cnt_d   = tx_cnt_q;
    if (tx_start) begin
      tx_busy_d  = 1'b1;
      txd_d      = 1'b0;
      tx_shift_d = {2'b11, tx_byte};
      tx_left_d  = 4'd10;
      tx_cnt_d   = FullBit;
    end else if (tx_busy_q) begin
      if (tx_cnt_q != 12'd0) begin
        tx_cnt_d = tx_cnt_q - 12'd1;
      end else if (tx_left_q == 4'd0) begin
        tx_busy_d = 1'b0;
      end else begin
        txd_d      = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_left_d  = tx_left_q - 4'd1;
        tx_cnt_d   = FullBit;
      end
    end
  end

  // Packet FSM
  p_state_e       p_state_q, p_state_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic           wr_q, wr_d;
  logic [8:0]     count_q, count_d;
  logic [7:0]     sum_q, sum_d;
  logic           hold_q, hold_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           active, timeout;

  assign active  = p_state_q inside {PAddrHi, PAddrLo, PLen, PData, PChk};
  assign timeout = active && !byte_valid && (to_cnt_q == ToW'(TimeoutCycles - 1));

  always_comb begin
    p_state_d = p_state_q;
    addr_d    = wr_q ? addr_q + 16'd1 : addr_q;  // advance after each strobe, wraps
    data_d    = data_q;
    wr_d      = 1'b0;
    count_d   = count_q;
    sum_d     = sum_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tx_start  = 1'b0;
    tx_byte   = ByteNak;
    to_cnt_d  = (active && !byte_valid) ? to_cnt_q + ToW'(1) : '0;
    case (p_state_q)
      PIdle: begin
        if (byte_valid && rx_shift_q == ByteLoad) begin
          p_state_d = PAddrHi;
          hold_d    = 1'b1;
        end
      end
      PAddrHi: begin
        if (byte_valid) begin
          addr_d    = {rx_shift_q, addr_q[7:0]};
          p_state_d = PAddrLo;
        end
      end
      PAddrLo: begin
        if (byte_valid) begin
          addr_d    = {addr_q[15:8], rx_shift_q};
          p_state_d = PLen;
        end
      end
      PLen: begin
        if (byte_valid) begin
          count_d   = (rx_shift_q == 8'd0) ? 9'd256 : {1'b0, rx_shift_q};
          sum_d     = 8'd0;
          p_state_d = PData;
        end
      end
      PData: begin
        if (byte_valid) begin
          data_d  = rx_shift_q;
          wr_d    = 1'b1;
          sum_d   = sum_q + rx_shift_q;
          count_d = count_q - 9'd1;
          if (count_q == 9'd1) p_state_d = PChk;
        end
      end
      PChk: begin
        if (byte_valid) begin
          tx_start  = 1'b1;
          p_state_d = PReply;
          if (8'(sum_q + rx_shift_q) == 8'd0) begin
            tx_byte = ByteAck;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PReply: begin
        if (!tx_busy_q) begin
          hold_d    = 1'b0;
          p_state_d = PIdle;
        end
      end
      default: p_state_d = PIdle;
    endcase
    if (active && frame_err) begin
      err_d     = 1'b1;
      tx_start  = 1'b1;
      tx_byte   = ByteNak;
      p_state_d = PReply;
    end else if (timeout) begin
      err_d     = 1'b1;
      hold_d    = 1'b0;
      p_state_d = PIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      tx_busy_q  <= 1'b0;
      txd_q      <= 1'b1;
      tx_shift_q <= '1;
      tx_left_q  <= '0;
      tx_cnt_q   <= '0;
      p_state_q  <= PIdle;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      rx_meta_q  <= rxd_line;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      tx_busy_q  <= tx_busy_d;
      txd_q      <= txd_d;
      tx_shift_q <= tx_shift_d;
      tx_left_q  <= tx_left_d;
      tx_cnt_q   <= tx_cnt_d;
      p_state_q  <= p_state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign txd_line    = txd_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_write   = wr_q;
  assign cpu_hold    = hold_q;
  assign load_done   = done_q;
  assign load_error  = err_q;

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader with a short bit period to keep runtime small.
module tb_serial_loader;

  localparam int unsigned Div    = 16;
  localparam int unsigned ToBits = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd_line;
  logic        txd_line;
  logic [15:0] mem_address;
  logic [7:0]  mem_data;
  logic        mem_write;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  serial_loader #(
    .CLK_RATE    (Div * 9600),
    .BAUD_RATE   (9600),
    .CLK_DIVISOR (Div),
    .TIMEOUT_BITS(ToBits)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd_line   (rxd_line),
    .txd_line   (txd_line),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_write  (mem_write),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observation state filled by the monitors
  int          cycle = 0;
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [7:0]  tx_bytes[$];
  int          done_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  int          pulse_cycle = 0, fall_cycle = 0;
  logic        hold_prev = 1'b0;

  logic [7:0]  pkt[$];
  logic [15:0] ea[$];
  logic [7:0]  ed[$];

  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (mem_write === 1'b1) begin
        wr_addr.push_back(mem_address);
        wr_data.push_back(mem_data);
      end
      if (load_done === 1'b1) done_cnt++;
      if (load_error === 1'b1) err_cnt++;
      if (load_done === 1'b1 || load_error === 1'b1) pulse_cycle = cycle;
      if (mem_write === 1'b1 && load_done === 1'b1) overlap_cnt++;
      if (hold_prev && cpu_hold === 1'b0) fall_cycle = cycle;
      hold_prev = (cpu_hold === 1'b1);
    end
  end

  // Reply decoder: samples each transmitted bit near its middle
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txd_line === 1'b0) begin
        repeat (Div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (Div) @(negedge clk);
          b[i] = txd_line;
        end
        repeat (Div) @(negedge clk);
        tx_bytes.push_back(b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    tx_bytes.delete();
    done_cnt    = 0;
    err_cnt     = 0;
    overlap_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd_line = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_line = b[i];
      repeat (Div) @(negedge clk);
    end
    rxd_line = 1'b1;
    repeat (Div) @(negedge clk);
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && cpu_hold !== 1'b0; i++) @(negedge clk);
    vectors++;
    if (cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: cpu_hold got %b, want 0 within bound", name, cpu_hold);
    end
    repeat (2 * Div) @(negedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rxd_line = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({txd_line, mem_write, mem_address, mem_data, cpu_hold, load_done, load_error}
        !== {1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset outputs: got txd=%b wr=%b a=%h d=%h hold=%b done=%b err=%b, want 1 0 0000 00 0 0 0",
               txd_line, mem_write, mem_address, mem_data, cpu_hold, load_done, load_error);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ack_packet();
    clear_mon();
    vectors++;
    if (cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL ack hold_before: got %b, want 0", cpu_hold);
    end
    pkt = '{8'h4C, 8'h02, 8'h00, 8'h03, 8'hA9, 8'h01, 8'h60, 8'hF6};
    send_pkt();
    vectors++;
    if (cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL ack hold_during_reply: got %b, want 1", cpu_hold);
    end
    wait_idle("ack");
    ea = '{16'h0200, 16'h0201, 16'h0202};
    ed = '{8'hA9, 8'h01, 8'h60};
    vectors++;
    if (wr_addr.size() != ea.size()) begin
      miscompares++;
      $display("FAIL ack write_count: got %0d, want %0d", wr_addr.size(), ea.size());
    end
    for (int i = 0; i < ea.size() && i < wr_addr.size(); i++) begin
      vectors++;
      if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL ack write%0d: got %h=%h, want %h=%h", i, wr_addr[i], wr_data[i], ea[i], ed[i]);
      end
    end
    vectors++;
    if (tx_bytes.size() != 1 || tx_bytes[0] !== 8'h06) begin
      miscompares++;
      $display("FAIL ack reply: got %0d bytes first %h, want 1 byte 06", tx_bytes.size(),
               tx_bytes.size() > 0 ? tx_bytes[0] : 8'hxx);
    end
    vectors++;
    if (done_cnt != 1 || err_cnt != 0) begin
      miscompares++;
      $display("FAIL ack pulses: got done=%0d err=%0d, want 1 0", done_cnt, err_cnt);
    end
    vectors++;
    if (fall_cycle - pulse_cycle < 11 * Div - 1 || fall_cycle - pulse_cycle > 11 * Div + 1) begin
      miscompares++;
      $display("FAIL ack hold_release: got %0d cycles, want %0d +-1", fall_cycle - pulse_cycle, 11 * Div);
    end
    vectors++;
    if (overlap_cnt != 0) begin
      miscompares++;
      $display("FAIL ack write_done_overlap: got %0d, want 0", overlap_cnt);
    end
  endtask

  task automatic test_wrap();
    clear_mon();
    pkt = '{8'h4C, 8'hFF, 8'hFE, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
    send_pkt();
    wait_idle("wrap");
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    ed = '{8'h11, 8'h22, 8'h33, 8'h44};
    vectors++;
    if (wr_addr.size() != ea.size()) begin
      miscompares++;
      $display("FAIL wrap write_count: got %0d, want %0d", wr_addr.size(), ea.size());
    end
    for (int i = 0; i < ea.size() && i < wr_addr.size(); i++) begin
      vectors++;
      if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL wrap write%0d: got %h=%h, want %h=%h", i, wr_addr[i], wr_data[i], ea[i], ed[i]);
      end
    end
    vectors++;
    if (tx_bytes.size() != 1 || tx_bytes[0] !== 8'h06 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL wrap reply: got %0d bytes done=%0d, want one 06 and done=1",
               tx_bytes.size(), done_cnt);
    end
  endtask

  task automatic test_nak();
    clear_mon();
    pkt = '{8'h4C, 8'h03, 8'h00, 8'h01, 8'hAA, 8'h00};
    send_pkt();
    wait_idle("nak");
    vectors++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 16'h0300 || wr_data[0] !== 8'hAA) begin
      miscompares++;
      $display("FAIL nak write: got %0d writes, want one 0300=AA", wr_addr.size());
    end
    vectors++;
    if (tx_bytes.size() != 1 || tx_bytes[0] !== 8'h15) begin
      miscompares++;
      $display("FAIL nak reply: got %0d bytes first %h, want 1 byte 15", tx_bytes.size(),
               tx_bytes.size() > 0 ? tx_bytes[0] : 8'hxx);
    end
    vectors++;
    if (err_cnt != 1 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL nak pulses: got err=%0d done=%0d, want 1 0", err_cnt, done_cnt);
    end
  endtask

  task automatic test_false_start_and_junk();
    clear_mon();
    rxd_line = 1'b0;
    repeat (Div / 4) @(negedge clk);
    rxd_line = 1'b1;
    repeat (12 * Div) @(negedge clk);
    vectors++;
    if (wr_addr.size() != 0 || cpu_hold !== 1'b0 || txd_line !== 1'b1 || err_cnt != 0 ||
        mem_address !== 16'h0301 || mem_data !== 8'hAA) begin
      miscompares++;
      $display("FAIL glitch: got writes=%0d hold=%b txd=%b err=%0d a=%h d=%h, want 0 0 1 0 0301 AA",
               wr_addr.size(), cpu_hold, txd_line, err_cnt, mem_address, mem_data);
    end
    send_byte(8'h41);
    repeat (14 * Div) @(negedge clk);
    vectors++;
    if (cpu_hold !== 1'b0 || tx_bytes.size() != 0 || err_cnt != 0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL junk_byte: got hold=%b replies=%0d err=%0d done=%0d, want 0 0 0 0",
               cpu_hold, tx_bytes.size(), err_cnt, done_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    pkt = '{8'h4C, 8'h10, 8'h00};
    send_pkt();
    vectors++;
    if (cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout hold_set: got %b, want 1", cpu_hold);
    end
    repeat (21 * Div) @(negedge clk);
    vectors++;
    if (err_cnt != 1 || cpu_hold !== 1'b0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL timeout abort: got err=%0d hold=%b done=%0d, want 1 0 0", err_cnt, cpu_hold, done_cnt);
    end
    repeat (12 * Div) @(negedge clk);
    vectors++;
    if (tx_bytes.size() != 0 || txd_line !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout no_reply: got %0d replies txd=%b, want 0 1", tx_bytes.size(), txd_line);
    end
    clear_mon();
    pkt = '{8'h4C, 8'h02, 8'h00, 8'h03, 8'hA9, 8'h01, 8'h60, 8'hF6};
    send_pkt();
    wait_idle("after_timeout");
    vectors++;
    if (wr_addr.size() != 3 || tx_bytes.size() != 1 || tx_bytes[0] !== 8'h06 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL after_timeout packet: got writes=%0d replies=%0d done=%0d, want 3 1 1",
               wr_addr.size(), tx_bytes.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] third;
    third = 8'h03;
    clear_mon();
    pkt = '{8'h4C, 8'h20, 8'h00, 8'h08, 8'h01, 8'h02};
    send_pkt();
    rxd_line = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd_line = third[i];
      repeat (Div) @(negedge clk);
    end
    vectors++;
    if (cpu_hold !== 1'b1 || mem_address !== 16'h2002 || mem_data !== 8'h02) begin
      miscompares++;
      $display("FAIL midpkt state: got hold=%b a=%h d=%h, want 1 2002 02", cpu_hold, mem_address, mem_data);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({txd_line, mem_write, mem_address, mem_data, cpu_hold, load_done, load_error}
        !== {1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midpkt reset: got txd=%b wr=%b a=%h d=%h hold=%b done=%b err=%b, want 1 0 0000 00 0 0 0",
               txd_line, mem_write, mem_address, mem_data, cpu_hold, load_done, load_error);
    end
    rxd_line = 1'b1;
    reset    = 1'b0;
    repeat (12 * Div) @(negedge clk);
    clear_mon();
    pkt = '{8'h4C, 8'h20, 8'h00, 8'h02, 8'h5A, 8'hA5, 8'h01};
    send_pkt();
    wait_idle("post_reset");
    vectors++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 16'h2000 || wr_data[0] !== 8'h5A ||
        wr_addr[1] !== 16'h2001 || wr_data[1] !== 8'hA5) begin
      miscompares++;
      $display("FAIL post_reset writes: got %0d writes, want 2000=5A 2001=A5", wr_addr.size());
    end
    vectors++;
    if (tx_bytes.size() != 1 || tx_bytes[0] !== 8'h06 || done_cnt != 1 || err_cnt != 0) begin
      miscompares++;
      $display("FAIL post_reset reply: got %0d replies done=%0d err=%0d, want one 06 1 0",
               tx_bytes.size(), done_cnt, err_cnt);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rxd_line = 1'b1;
    test_reset();
    test_ack_packet();
    test_wrap();
    test_nak();
    test_false_start_and_junk();
    test_timeout();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
